// File: rtl/ram_reader.sv
// SRAM readback engine: reads num_words words starting at base_addr and streams
// each word MSB first over a valid/ready serial port. Every output is registered.
module ram_reader #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_words,
   output logic              cs_n,
   output logic              we_n,
   output logic [ADDR_W-1:0] address,
   input  logic              ry,
   input  logic [DATA_W-1:0] read_data,
   output logic              P_out,
   output logic              P_valid,
   input  logic              P_ready,
   output logic              busy,
   output logic              read_done,
   output logic              rd_err
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] remaining_q, remaining_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
   logic              cs_n_q, cs_n_d;
   logic              we_n_q;
   logic [ADDR_W-1:0] address_q, address_d;
   logic              p_out_q, p_out_d;
   logic              p_valid_q, p_valid_d;
   logic              busy_q, busy_d;
   logic              read_done_q, read_done_d;
   logic              rd_err_q, rd_err_d;
   logic              xfer;

   assign xfer = p_valid_q && P_ready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      rd_err_d    = rd_err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_words != '0) begin
                  state_d     = S_REQ;
                  addr_d      = base_addr;
                  remaining_d = num_words;
                  rd_err_d    = 1'b0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_REQ: begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
         end
         S_WAIT: begin
            if (ry) begin
               state_d   = S_SHIFT;
               shift_d   = read_data;
               bit_cnt_d = '0;
            end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
               state_d  = S_DONE;
               rd_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + TW'(1);
            end
         end
         S_SHIFT: begin
            if (xfer) begin
               shift_d   = shift_q << 1;
               bit_cnt_d = bit_cnt_q + BW'(1);
               if (bit_cnt_q == BW'(DATA_W - 1)) begin
                  bit_cnt_d   = '0;
                  remaining_d = remaining_q - ADDR_W'(1);
                  if (remaining_q == ADDR_W'(1)) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_REQ;
                     addr_d  = addr_q + ADDR_W'(1);
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Port values are derived from the next state so they line up with it;
   // read_done trails DONE by one cycle so the pulse lands as the run closes.
   always_comb begin
      cs_n_d      = !((state_d == S_REQ) || (state_d == S_WAIT));
      address_d   = (state_d == S_REQ) ? addr_d : address_q;
      p_valid_d   = (state_d == S_SHIFT);
      p_out_d     = (state_d == S_SHIFT) ? shift_d[DATA_W-1] : 1'b0;
      busy_d      = (state_d != S_IDLE);
      read_done_d = (state_q == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         cs_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         address_q   <= '0;
         p_out_q     <= 1'b0;
         p_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
         read_done_q <= 1'b0;
         rd_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         cs_n_q      <= cs_n_d;
         we_n_q      <= 1'b1;
         address_q   <= address_d;
         p_out_q     <= p_out_d;
         p_valid_q   <= p_valid_d;
         busy_q      <= busy_d;
         read_done_q <= read_done_d;
         rd_err_q    <= rd_err_d;
      end
   end

   assign cs_n      = cs_n_q;
   assign we_n      = we_n_q;
   assign address   = address_q;
   assign P_out     = p_out_q;
   assign P_valid   = p_valid_q;
   assign busy      = busy_q;
   assign read_done = read_done_q;
   assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: SRAM model with programmable ready, serial
// collector and stall monitor; expected values are hand-computed.
module tb_ram_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  base_addr = 8'h00;
   logic [7:0]  num_words = 8'h00;
   logic        cs_n, we_n;
   logic [7:0]  address;
   logic        ry;
   logic [31:0] read_data;
   logic        P_out, P_valid;
   logic        P_ready = 1'b1;
   logic        busy, read_done, rd_err;

   ram_reader #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .num_words(num_words), .cs_n(cs_n), .we_n(we_n), .address(address),
      .ry(ry), .read_data(read_data), .P_out(P_out), .P_valid(P_valid),
      .P_ready(P_ready), .busy(busy), .read_done(read_done), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   // SRAM model: ready one cycle after chip select falls, when enabled
   logic [31:0] mem [0:255];
   logic        ry_en = 1'b1;
   int          cs_cnt = 0;
   always @(posedge clk) cs_cnt <= cs_n ? 0 : cs_cnt + 1;
   assign ry        = ry_en && !cs_n && (cs_cnt >= 1);
   assign read_data = mem[address];

   logic rdy_rand = 1'b0;
   always @(negedge clk) P_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

   // Monitor
   logic        mon_clr = 1'b0;
   logic [63:0] bits;
   int          nbits, cs_low, pv_cyc, done_cnt, naddr, stall_viol;
   logic [7:0]  addr_log [0:3];
   logic        stall_pend, stall_bit;
   always @(posedge clk) begin
      if (mon_clr) begin
         bits = '0; nbits = 0; cs_low = 0; pv_cyc = 0; done_cnt = 0;
         naddr = 0; stall_viol = 0; stall_pend = 1'b0; stall_bit = 1'b0;
         for (int i = 0; i < 4; i++) addr_log[i] = 8'h00;
      end else begin
         if (P_valid && P_ready) begin
            bits = {bits[62:0], P_out};
            nbits++;
         end
         if (!cs_n) cs_low++;
         if (P_valid) pv_cyc++;
         if (read_done) done_cnt++;
         if (ry) begin
            addr_log[naddr[1:0]] = address;
            naddr++;
         end
         if (stall_pend && !(P_valid && P_out == stall_bit)) stall_viol++;
         stall_pend = P_valid && !P_ready;
         stall_bit  = P_out;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      @(negedge clk) mon_clr = 1'b1;
      @(negedge clk) mon_clr = 1'b0;
   endtask

   // Pulses start; optionally re-pulses start while busy; waits for read_done
   task automatic run(input logic [7:0] b, input logic [7:0] n, input bit extra, output int cyc);
      @(negedge clk);
      base_addr = b; num_words = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!read_done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = extra && (cyc == 5);
         if (start) begin base_addr = 8'h40; num_words = 8'h03; end
      end
      start = 1'b0;
      if (!read_done) check_eq("done_bound", 64'(read_done), 64'd1);
      $display("run base=%02h num=%0d cycles=%0d bits=%0d rd_err=%0b", b, n, cyc, nbits, rd_err);
   endtask

   int cyc;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'hA5A5_0001;
      mem[8'h11] = 32'h8000_00FF;
      mem[8'hFF] = 32'h1234_5678;
      mem[8'h00] = 32'h9ABC_DEF0;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_cs_n", 64'(cs_n), 64'd1);
      check_eq("rst_we_n", 64'(we_n), 64'd1);
      check_eq("rst_addr", 64'(address), 64'd0);
      check_eq("rst_pvalid_pout_busy_done_err",
               64'({P_valid, P_out, busy, read_done, rd_err}), 64'd0);
      @(negedge clk) rst = 1'b1;
      clear_mon();

      // Two-word run, always ready
      run(8'h10, 8'd2, 1'b0, cyc);
      check_eq("t1_latency", 64'(cyc), 64'd69);
      @(negedge clk);
      check_eq("t1_bits", bits, 64'hA5A5_0001_8000_00FF);
      check_eq("t1_nbits", 64'(nbits), 64'd64);
      check_eq("t1_addr0", 64'(addr_log[0]), 64'h10);
      check_eq("t1_addr1", 64'(addr_log[1]), 64'h11);
      check_eq("t1_cs_low", 64'(cs_low), 64'd4);
      check_eq("t1_done", 64'(done_cnt), 64'd1);
      check_eq("t1_busy_err", 64'({busy, rd_err}), 64'd0);

      // Same run with random backpressure and an ignored start while busy
      clear_mon();
      rdy_rand = 1'b1;
      run(8'h10, 8'd2, 1'b1, cyc);
      rdy_rand = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("t2_bits", bits, 64'hA5A5_0001_8000_00FF);
      check_eq("t2_nbits", 64'(nbits), 64'd64);
      check_eq("t2_stall_hold", 64'(stall_viol), 64'd0);
      check_eq("t2_addr", 64'({addr_log[0], addr_log[1]}), 64'h1011);
      check_eq("t2_naddr", 64'(naddr), 64'd2);
      check_eq("t2_single_run", 64'(done_cnt), 64'd1);
      check_eq("t2_cs_low", 64'(cs_low), 64'd4);

      // Zero-length run
      clear_mon();
      run(8'h10, 8'd0, 1'b0, cyc);
      check_eq("t3_latency", 64'(cyc), 64'd1);
      @(negedge clk);
      check_eq("t3_cs_low", 64'(cs_low), 64'd0);
      check_eq("t3_done", 64'(done_cnt), 64'd1);
      check_eq("t3_pv", 64'(pv_cyc), 64'd0);

      // Ready never arrives
      clear_mon();
      ry_en = 1'b0;
      run(8'h20, 8'd3, 1'b0, cyc);
      ry_en = 1'b1;
      check_eq("t4_latency", 64'(cyc), 64'd17);
      check_eq("t4_rd_err", 64'(rd_err), 64'd1);
      check_eq("t4_cs_n", 64'(cs_n), 64'd1);
      @(negedge clk);
      check_eq("t4_pv", 64'(pv_cyc), 64'd0);
      check_eq("t4_cs_low", 64'(cs_low), 64'd16);
      check_eq("t4_done", 64'(done_cnt), 64'd1);
      check_eq("t4_err_sticky", 64'(rd_err), 64'd1);
      #2 rst = 1'b0;
      #1 check_eq("t4_rst_err", 64'(rd_err), 64'd0);
      @(negedge clk) rst = 1'b1;

      // Address wrap
      clear_mon();
      run(8'hFF, 8'd2, 1'b0, cyc);
      @(negedge clk);
      check_eq("t5_addr0", 64'(addr_log[0]), 64'hFF);
      check_eq("t5_addr1", 64'(addr_log[1]), 64'h00);
      check_eq("t5_bits", bits, 64'h1234_5678_9ABC_DEF0);
      check_eq("t5_err_clr", 64'(rd_err), 64'd0);

      // Asynchronous reset during shifting of the first word
      clear_mon();
      @(negedge clk);
      base_addr = 8'h10; num_words = 8'd2; start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("t6_pv_before", 64'(P_valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      check_eq("t6_cs_we", 64'({cs_n, we_n}), 64'b11);
      check_eq("t6_addr", 64'(address), 64'd0);
      check_eq("t6_outs", 64'({P_out, P_valid, busy, read_done, rd_err}), 64'd0);
      @(negedge clk) rst = 1'b1;
      clear_mon();
      repeat (20) @(negedge clk);
      check_eq("t6_no_access", 64'(cs_low), 64'd0);
      check_eq("t6_idle", 64'({busy, P_valid, done_cnt != 0}), 64'd0);
      $display("reset mid-run checked, idle for 20 cycles");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
